// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition codes and flag bit positions shared by the conditional-execution unit
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational evaluation of a condition field against stored flags
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = ~z & (n == v);
      COND_LE: CondEx = z | (n != v);
      // NV is deliberately executed as unconditional, same as AL
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - flags register, captured condition result and write-enable gating
module cond_logic
  import cond_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       CondCapture,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondExR
);

  logic [1:0] flags_nz_q, flags_nz_d;
  logic [1:0] flags_cv_q, flags_cv_d;
  logic       cond_ex_r_q, cond_ex_r_d;
  logic       cond_ex;
  logic       ce;

  assign Flags   = {flags_nz_q, flags_cv_q};
  assign CondExR = cond_ex_r_q;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (cond_ex)
  );

  // Outside the decode strobe the multicycle controller relies on the latched result
  assign ce = CondCapture ? cond_ex : cond_ex_r_q;

  always_comb begin
    flags_nz_d  = (FlagW[1] && ce) ? ALUFlags[FLAG_N:FLAG_Z] : flags_nz_q;
    flags_cv_d  = (FlagW[0] && ce) ? ALUFlags[FLAG_C:FLAG_V] : flags_cv_q;
    cond_ex_r_d = CondCapture ? cond_ex : cond_ex_r_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_nz_q  <= 2'b00;
      flags_cv_q  <= 2'b00;
      cond_ex_r_q <= 1'b0;
    end else begin
      flags_nz_q  <= flags_nz_d;
      flags_cv_q  <= flags_cv_d;
      cond_ex_r_q <= cond_ex_r_d;
    end
  end

  assign PCSrc    = PCS  & ce & ~reset;
  assign RegWrite = RegW & ce & ~NoWrite & ~reset;
  assign MemWrite = MemW & ce & ~reset;

endmodule
